uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 17 +
 rtl/parity_calc.sv | 18 +
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
package uart_pkg;

    // Frame-level state encoding shared by the TX and RX state machines.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Parity-type selector values.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator.
// Even parity is the XOR of all data bits; odd parity is its complement.
module parity_calc
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_type,
    output logic             parity_bit
);

    // Fold the word down to one bit, then invert it for odd parity.
    always_comb begin
        parity_bit = (^data) ^ (par_type == PAR_ODD);
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one bit per clk cycle.
// Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, stop (1).
// The word and its parity configuration are captured only in IDLE, so
// input activity while a frame is in flight cannot disturb that frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    input  logic                  data_valid_in,
    input  logic                  par_en_in,
    input  logic                  par_type_in,
    output logic                  tx_out,
    output logic                  busy_out
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_type_reg;
    logic                  parity_bit;

    // Parity is derived from the latched word only, never from the live inputs.
    parity_calc #(
        .WIDTH (DATA_WIDTH)
    ) u_parity (
        .data       (data_reg),
        .par_type   (par_type_reg),
        .parity_bit (parity_bit)
    );

    // Index of the data bit that goes out on the next cycle.
    always_comb begin
        next_cnt = bit_cnt + CNT_W'(1);
    end

    // Frame FSM with bit counter, data latch and registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            data_reg     <= '0;
            par_en_reg   <= 1'b0;
            par_type_reg <= PAR_EVEN;
            tx_out       <= 1'b1;
            busy_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out   <= 1'b1;
                    busy_out <= 1'b0;
                    bit_cnt  <= '0;
                    if (data_valid_in) begin
                        data_reg     <= p_data_in;
                        par_en_reg   <= par_en_in;
                        par_type_reg <= par_type_in;
                        state        <= START;
                        tx_out       <= 1'b0;
                        busy_out     <= 1'b1;
                    end
                end

                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tx_out  <= data_reg[0];
                end

                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_reg) begin
                            state  <= PARITY;
                            tx_out <= parity_bit;
                        end else begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= next_cnt;
                        tx_out  <= data_reg[next_cnt];
                    end
                end

                PARITY: begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                end

                STOP: begin
                    state    <= IDLE;
                    tx_out   <= 1'b1;
                    busy_out <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bit_cnt  <= '0;
                    tx_out   <= 1'b1;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected {tx_out, busy_out} per cycle
// are queued when a word is requested and popped as the line is sampled.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] p_data_in;
    logic       data_valid_in;
    logic       par_en_in;
    logic       par_type_in;
    logic       tx_out;
    logic       busy_out;

    logic [1:0] exp_q[$];
    int         compare_count;
    int         mismatch_count;

    uart_tx #(
        .DATA_WIDTH (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p_data_in     (p_data_in),
        .data_valid_in (data_valid_in),
        .par_en_in     (par_en_in),
        .par_type_in   (par_type_in),
        .tx_out        (tx_out),
        .busy_out      (busy_out)
    );

    // Free-running clock, 10 time units per bit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something goes badly wrong.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive a request (at a negedge) and queue the frame the line should show.
    task automatic apply_stimulus(input logic [7:0] d, input logic pe, input logic pt);
        p_data_in     = d;
        par_en_in     = pe;
        par_type_in   = pt;
        data_valid_in = 1'b1;
        exp_q.push_back(2'b01);
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
        if (pe) exp_q.push_back({(^d) ^ pt, 1'b1});
        exp_q.push_back(2'b11);
    endtask

    // Sample each queued cycle; optionally hold valid or inject a spurious request.
    task automatic run_frame(input string tag, input bit hold, input int glitch_at);
        logic [1:0] exp;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (!hold) data_valid_in = 1'b0;
            if (k == glitch_at) begin
                data_valid_in = 1'b1;
                p_data_in     = 8'hFF;
                par_en_in     = 1'b1;
            end
            exp = exp_q.pop_front();
            check_output($sformatf("%s tx[%0d]", tag, k), 32'(tx_out), 32'(exp[1]));
            check_output($sformatf("%s busy[%0d]", tag, k), 32'(busy_out), 32'(exp[0]));
            k++;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check_output($sformatf("%s idle tx", tag), 32'(tx_out), 32'd1);
        check_output($sformatf("%s idle busy", tag), 32'(busy_out), 32'd0);
    endtask

    // Main sequence.
    initial begin
        logic [1:0] exp;
        logic [7:0] rd;
        logic       rpe;
        logic       rpt;
        compare_count  = 0;
        mismatch_count = 0;
        reset          = 1'b1;
        data_valid_in  = 1'b1;
        p_data_in      = 8'hFF;
        par_en_in      = 1'b1;
        par_type_in    = 1'b0;

        // Reset with a request pending: the request must be ignored.
        repeat (3) @(negedge clk);
        check_output("reset tx", 32'(tx_out), 32'd1);
        check_output("reset busy", 32'(busy_out), 32'd0);
        reset         = 1'b0;
        data_valid_in = 1'b0;
        check_idle("post-reset");

        apply_stimulus(8'hA5, 1'b1, 1'b0);
        run_frame("A5 even", 1'b0, -1);
        check_idle("A5 even");

        apply_stimulus(8'h07, 1'b1, 1'b1);
        run_frame("07 odd", 1'b0, -1);
        check_idle("07 odd");

        apply_stimulus(8'h00, 1'b0, 1'b0);
        run_frame("00 nopar", 1'b0, -1);
        check_idle("00 nopar");

        // A request for 0xFF during data bits must be dropped.
        apply_stimulus(8'h3C, 1'b0, 1'b0);
        run_frame("3C glitch", 1'b0, 3);
        check_idle("3C glitch a");
        check_idle("3C glitch b");

        // Back-to-back with valid held high: exactly one idle cycle between frames.
        apply_stimulus(8'h55, 1'b1, 1'b0);
        run_frame("55 b2b", 1'b1, -1);
        p_data_in = 8'hAA;
        check_idle("b2b gap");
        apply_stimulus(8'hAA, 1'b1, 1'b0);
        run_frame("AA b2b", 1'b0, -1);
        check_idle("AA b2b");

        // Reset while data bit 3 is on the line aborts the frame with no stop bit.
        apply_stimulus(8'hA5, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            data_valid_in = 1'b0;
            exp = exp_q.pop_front();
            check_output($sformatf("abort tx[%0d]", k), 32'(tx_out), 32'(exp[1]));
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_output("abort tx", 32'(tx_out), 32'd1);
        check_output("abort busy", 32'(busy_out), 32'd0);
        reset = 1'b0;
        check_idle("after abort");

        apply_stimulus(8'h3C, 1'b1, 1'b1);
        run_frame("3C odd", 1'b0, -1);
        check_idle("3C odd");

        // A few random words and configurations.
        for (int n = 0; n < 4; n++) begin
            rd  = 8'($urandom_range(0, 255));
            rpe = 1'($urandom_range(0, 1));
            rpt = 1'($urandom_range(0, 1));
            apply_stimulus(rd, rpe, rpt);
            run_frame($sformatf("rand%0d %02h", n, rd), 1'b0, -1);
            check_idle($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
